uart_word_tx_ctrl: RTL and testbench
====================================

// Module: uart_word_tx_ctrl
// PURPOSE
//  Serialises one DATA_W-bit word into NUM_BYTES bytes for a byte-wide UART transmitter.
//  Sits between a data producer (sensor/ALU result, one-cycle trigger) and the UART TX core.
//  Generalises the fixed 16-bit two-byte sender: parametrised width, byte order, ACK timeout, busy/done status.
// PARAMETERS
//  DATA_W     16  word width in bits; multiple of 8, 8..64; NUM_BYTES = DATA_W/8 (localparam)
//  MSB_FIRST  0   0: byte 0 = raw_data[7:0] sent first; 1: most-significant byte first
//  ACK_TO     4   max cycles to wait for tx_busy to rise after tx_start; range 1..15
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset_n    in   1       synchronous reset, active-low
//  trigger    in   1       start request; sampled only in IDLE
//  raw_data   in   DATA_W  word to send; captured on the cycle trigger is accepted
//  tx_busy    in   1       UART core busy flag
//  tx_start   out  1       one-cycle pulse; UART loads tx_data on this cycle
//  tx_data    out  8       byte to transmit, registered, stable from tx_start until the next byte
//  busy       out  1       high from trigger acceptance until return to IDLE
//  done       out  1       one-cycle pulse when the last byte is confirmed sent
//  state_id   out  3       current FSM encoding, for debug/LEDs
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, tx_start=0, tx_data=8'h00, busy=0, done=0, byte index=0, shadow word=0.
//  Reset mid-transfer aborts immediately; the remaining bytes are dropped, and no done pulse is issued.
//  FSM states: IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, FINISH.
//   IDLE: trigger=1 -> capture raw_data into shadow, idx=0, go to LOAD. Otherwise stay.
//   LOAD: register tx_data = selected byte of the shadow word -> SEND.
//    Select raw byte idx (MSB_FIRST=0) or byte NUM_BYTES-1-idx (MSB_FIRST=1).
//   SEND: tx_start=1 for exactly this cycle; clear the timeout counter -> WAIT_ACK.
//   WAIT_ACK: tx_busy=1 -> WAIT_DONE. If the counter reaches ACK_TO, treat the byte as sent -> WAIT_DONE.
//    This guards against UARTs whose busy is never seen.
//   WAIT_DONE: tx_busy=0 -> if idx==NUM_BYTES-1, go to FINISH; else idx++ and go to LOAD.
//   FINISH: done=1 for one cycle -> IDLE.
//  Timing: trigger at cycle T gives tx_start at T+2. Per byte, the minimum is 4 cycles plus the UART frame time.
//  trigger while busy=1: ignored, not queued. raw_data changes after capture have no effect.
//  tx_busy already high when SEND is entered: WAIT_ACK exits on the next cycle, so no deadlock.
//  Simultaneous trigger and FINISH: the trigger is ignored, and the next trigger is accepted in IDLE.
//  busy = (state != IDLE). done and tx_start are registered, glitch-free pulses.
//  idx width = $clog2(NUM_BYTES) or 1, whichever is larger; no wrap beyond NUM_BYTES-1.
// CONFIGURATION
//  Macro UART_WORD_TX_CHECKSUM_EN:
//   Defined: after the last data byte, one extra byte is sent, equal to the XOR of all NUM_BYTES data bytes.
//    It uses the same LOAD/SEND/WAIT_ACK/WAIT_DONE sequence. done fires after the checksum byte's WAIT_DONE.
//   Undefined: exactly NUM_BYTES bytes are sent, and no checksum logic is synthesised.
// STRUCTURE
//  Package uart_tx_pkg:
//   typedef enum logic [2:0] tx_ctrl_state_t {IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, FINISH}
//   localparam UART_BYTE_W = 8
//   function byte_sel(word, idx, msb_first)
//  No sub-module. The block is one two-process FSM (always_comb next-state/outputs plus always_ff registers)
//  with the shadow register, index counter and timeout counter.
// TESTING
//  1. DATA_W=16, MSB_FIRST=0, raw=16'hBEEF, trigger 1 cycle; UART model busy 10 cycles after each start
//     -> tx_data 8'hEF then 8'hBE, exactly 2 tx_start pulses, done once, busy low after.
//  2. DATA_W=32, MSB_FIRST=1, raw=32'h12345678 -> bytes 12,34,56,78 in order; tx_start at T+2 after trigger.
//  3. tx_busy tied 0, ACK_TO=4 -> each byte leaves WAIT_ACK after 4 cycles; the transfer completes, no hang.
//  4. Second trigger with raw=16'h0000 mid-transfer of 16'hA55A
//     -> ignored; only 5A, A5 are sent, and exactly one done pulse.
//  5. reset_n low for 1 cycle during WAIT_DONE of byte 0
//     -> IDLE next cycle, all outputs at reset values, no done; a new trigger then works normally.
//  6. With UART_WORD_TX_CHECKSUM_EN, raw=16'hBEEF -> bytes EF, BE, 51; done after the third byte.

Source files
------------

// File: rtl/uart_word_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared types, constants and byte-selection helper for the
//               word-to-byte UART transmit controller.
//               Contents:
//                 UART_BYTE_W     - width of one UART payload byte
//                 MAX_WORD_W      - widest word the helper can slice
//                 tx_ctrl_state_t - controller FSM states (also the state_id
//                                   debug encoding)
//                 byte_sel()      - picks one byte of a word, either order
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int MAX_WORD_W  = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } tx_ctrl_state_t;

  // Returns byte number idx of word in transmit order. With msb_first set,
  // transmit slot 0 maps to the most-significant populated byte, which is why
  // the populated byte count is needed.
  function automatic logic [UART_BYTE_W-1:0] byte_sel(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           idx,
    input bit                    msb_first,
    input int unsigned           num_bytes = MAX_WORD_W / UART_BYTE_W
  );
    int unsigned           pos;
    logic [MAX_WORD_W-1:0] shifted;
    pos     = msb_first ? (num_bytes - 1 - idx) : idx;
    shifted = word >> (UART_BYTE_W * pos);
    return shifted[UART_BYTE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx_ctrl_if
// Description : Bundles the producer trigger/data, the UART core handshake and
//               the status outputs of uart_word_tx_ctrl.
//               Signals:
//                 trigger   producer -> ctrl  start request
//                 raw_data  producer -> ctrl  word to send (DATA_W bits)
//                 tx_busy   UART     -> ctrl  UART core busy flag
//                 tx_start  ctrl -> UART      one-cycle load pulse
//                 tx_data   ctrl -> UART      byte to transmit
//                 busy      ctrl -> producer  transfer in progress
//                 done      ctrl -> producer  one-cycle completion pulse
//                 state_id  ctrl -> debug     current FSM encoding
//               Modports: slave = controller, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_word_tx_ctrl_if #(
  parameter int DATA_W = 16
);
  import uart_tx_pkg::*;

  logic                   trigger;
  logic [DATA_W-1:0]      raw_data;
  logic                   tx_busy;
  logic                   tx_start;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   busy;
  logic                   done;
  logic [2:0]             state_id;

  modport master (
    output trigger, raw_data, tx_busy,
    input  tx_start, tx_data, busy, done, state_id
  );

  modport slave (
    input  trigger, raw_data, tx_busy,
    output tx_start, tx_data, busy, done, state_id
  );

endinterface
`default_nettype wire

// File: rtl/uart_word_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx_ctrl
// Description : Serialises one DATA_W-bit word into DATA_W/8 bytes for a
//               byte-wide UART transmitter, one LOAD/SEND/WAIT_ACK/WAIT_DONE
//               round per byte, then a one-cycle done pulse.
//               Ports:
//                 clk      - system clock, posedge
//                 reset_n  - synchronous active-low reset
//                 bus      - uart_word_tx_ctrl_if.slave (trigger, raw_data,
//                            tx_busy in; tx_start, tx_data, busy, done,
//                            state_id out)
//               Parameters: DATA_W (8..64, multiple of 8), MSB_FIRST,
//                           ACK_TO (1..15 cycles to wait for tx_busy).
//               Build option: define UART_WORD_TX_CHECKSUM_EN to append one
//               XOR-of-all-data-bytes checksum byte after the data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx_ctrl #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int ACK_TO    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_word_tx_ctrl_if.slave  bus
);
  import uart_tx_pkg::*;

  localparam int NUM_BYTES = DATA_W / UART_BYTE_W;
`ifdef UART_WORD_TX_CHECKSUM_EN
  // The checksum rides in an extra slot after the data bytes.
  localparam int LAST_IDX  = NUM_BYTES;
`else
  localparam int LAST_IDX  = NUM_BYTES - 1;
`endif
  localparam int IDX_W     = (LAST_IDX < 2) ? 1 : $clog2(LAST_IDX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX_V = IDX_W'(LAST_IDX);
  localparam logic [3:0]       ACK_TO_V   = 4'(ACK_TO);

  tx_ctrl_state_t         state_q,    state_d;
  logic [DATA_W-1:0]      shadow_q,   shadow_d;
  logic [IDX_W-1:0]       idx_q,      idx_d;
  logic [3:0]             cnt_q,      cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q,  tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   done_q,     done_d;

  logic [UART_BYTE_W-1:0] sel_byte;

`ifdef UART_WORD_TX_CHECKSUM_EN
  logic [UART_BYTE_W-1:0] chk_byte;

  always_comb begin
    chk_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      chk_byte = chk_byte ^ shadow_q[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  always_comb begin
    if (idx_q == LAST_IDX_V) begin
      sel_byte = chk_byte;
    end else begin
      sel_byte = byte_sel(64'(shadow_q), 32'(idx_q), MSB_FIRST, NUM_BYTES);
    end
  end
`else
  assign sel_byte = byte_sel(64'(shadow_q), 32'(idx_q), MSB_FIRST, NUM_BYTES);
`endif

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;

    case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          shadow_d = bus.raw_data;
          idx_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = sel_byte;
        state_d   = SEND;
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A UART whose busy flag never shows up must not stall us: after
        // ACK_TO cycles the byte is assumed to be on its way.
        cnt_d = cnt_q + 4'd1;
        if (bus.tx_busy || (cnt_d == ACK_TO_V)) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == LAST_IDX_V) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered pulses: high exactly while the FSM sits in SEND / FINISH.
    tx_start_d = (state_d == SEND);
    done_d     = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.state_id = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_tx_ctrl
// Description : Self-checking bench for uart_word_tx_ctrl. Two instances:
//               A = 16-bit LSB-first, B = 32-bit MSB-first, both ACK_TO=4.
//               A small UART model answers tx_start with a busy window of
//               ulen cycles (0 = never busy) or ties tx_busy low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx_ctrl;
  import uart_tx_pkg::*;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_word_tx_ctrl_if #(.DATA_W(16)) ifa ();
  uart_word_tx_ctrl_if #(.DATA_W(32)) ifb ();

  uart_word_tx_ctrl #(.DATA_W(16), .MSB_FIRST(1'b0), .ACK_TO(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  uart_word_tx_ctrl #(.DATA_W(32), .MSB_FIRST(1'b1), .ACK_TO(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // UART model mode: 0 = busy for ulen cycles after each start, 1 = tied low
  int umode = 0;
  int ulen  = 10;
  int rem_a = 0;
  int rem_b = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int         st_a[$];
  int         st_b[$];
  int         done_a = 0;
  int         done_b = 0;
  logic [7:0] exp_q[$];

  // Monitor and UART model, all sampled/driven on the falling edge.
  initial begin
    ifa.tx_busy = 1'b0;
    ifb.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.tx_start) begin got_a.push_back(ifa.tx_data); st_a.push_back(cyc); end
      if (ifb.tx_start) begin got_b.push_back(ifb.tx_data); st_b.push_back(cyc); end
      if (ifa.done) done_a++;
      if (ifb.done) done_b++;
      if (umode == 1) begin
        ifa.tx_busy = 1'b0;
        ifb.tx_busy = 1'b0;
      end else begin
        if (ifa.tx_start) rem_a = ulen;
        if (ifb.tx_start) rem_b = ulen;
        if (rem_a > 0) begin ifa.tx_busy = 1'b1; rem_a--; end else ifa.tx_busy = 1'b0;
        if (rem_b > 0) begin ifb.tx_busy = 1'b1; rem_b--; end else ifb.tx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes in transmit order straight from the word, plus the XOR
  // checksum byte when that option is built in.
  function automatic void build_exp(input logic [63:0] w, input int nb, input bit msbf);
`ifdef UART_WORD_TX_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    exp_q.delete();
    for (int k = 0; k < nb; k++) begin
      int p;
      p = msbf ? (nb - 1 - k) : k;
      exp_q.push_back(8'((w >> (8 * p)) & 64'hFF));
`ifdef UART_WORD_TX_CHECKSUM_EN
      x = x ^ exp_q[k];
`endif
    end
`ifdef UART_WORD_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? ifa.busy : ifb.busy;
  endfunction

  function automatic logic [2:0] get_state(input int sel);
    return (sel == 0) ? ifa.state_id : ifb.state_id;
  endfunction

  task automatic drive(input int sel, input logic trig, input logic [63:0] w);
    if (sel == 0) begin ifa.trigger = trig; ifa.raw_data = w[15:0]; end
    else          begin ifb.trigger = trig; ifb.raw_data = w[31:0]; end
  endtask

  // One full transfer. gap > 0 checks the tx_start spacing; inject > 0
  // pulses a zero-word trigger at that cycle of the transfer; inject < 0
  // raises trigger while the FSM is in FINISH.
  task automatic run_xfer(input string tag, input int sel, input logic [63:0] w,
                          input int gap, input int inject);
    logic [7:0] got[$];
    int         st[$];
    int         dn;
    int         t0;
    int         nb;
    bit         ended;
    logic [63:0] obs;
    nb = (sel == 0) ? 2 : 4;
    build_exp(w, nb, sel == 1);
    @(negedge clk);
    got_a.delete(); got_b.delete(); st_a.delete(); st_b.delete();
    done_a = 0; done_b = 0;
    t0 = cyc;
    drive(sel, 1'b1, w);
    @(negedge clk);
    drive(sel, 1'b0, {$urandom, $urandom});
    check({tag, "_busy_hi"}, 64'(get_busy(sel)), 64'd1);
    ended = 1'b0;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      if ((inject > 0 && i == inject) || (inject < 0 && get_state(sel) == 3'(FINISH)))
        drive(sel, 1'b1, 64'd0);
      else
        drive(sel, 1'b0, {$urandom, $urandom});
      if (!get_busy(sel)) begin ended = 1'b1; break; end
    end
    check({tag, "_no_timeout"}, 64'(ended), 64'd1);
    drive(sel, 1'b0, 64'd0);
    repeat (4) @(negedge clk);
    check({tag, "_busy_lo"}, 64'(get_busy(sel)), 64'd0);
    if (sel == 0) begin got = got_a; st = st_a; dn = done_a; end
    else          begin got = got_b; st = st_b; dn = done_b; end
    check({tag, "_nbytes"}, 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = (k < got.size()) ? 64'(got[k]) : 64'hFFFF;
      check($sformatf("%s_byte%0d", tag, k), obs, 64'(exp_q[k]));
    end
    if (st.size() > 0) check({tag, "_start_lat"}, 64'(st[0] - t0), 64'd2);
    if (gap > 0)
      for (int k = 1; k < st.size(); k++)
        check($sformatf("%s_gap%0d", tag, k), 64'(st[k] - st[k-1]), 64'(gap));
    check({tag, "_done_cnt"}, 64'(dn), 64'd1);
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0;
    drive(0, 1'b0, 64'd0);
    drive(1, 1'b0, 64'd0);
    repeat (2) @(negedge clk);
    check("rst_state", 64'(ifa.state_id), 64'(IDLE));
    check("rst_start", 64'(ifa.tx_start), 64'd0);
    check("rst_data",  64'(ifa.tx_data),  64'd0);
    check("rst_busy",  64'(ifa.busy),     64'd0);
    check("rst_done",  64'(ifa.done),     64'd0);
    check("rst_busy_b", 64'(ifb.busy),    64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    umode = 0; ulen = 10;
    run_xfer("beef", 0, 64'hBEEF, 0, 0);
    run_xfer("w32", 1, 64'h12345678, 0, 0);

    umode = 1;
    run_xfer("tie0_a", 0, 64'h1357, 3 + 4, 0);
    run_xfer("tie0_b", 1, 64'hCAFEF00D, 3 + 4, 0);

    umode = 0; ulen = 10;
    run_xfer("retrig", 0, 64'hA55A, 0, 3);
    run_xfer("fin_trig", 0, 64'h0F1E, 0, -1);

    // Reset during WAIT_DONE of byte 0.
    @(negedge clk);
    got_a.delete(); st_a.delete(); done_a = 0;
    drive(0, 1'b1, 64'h1234);
    @(negedge clk);
    drive(0, 1'b0, 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ifa.state_id == 3'(WAIT_DONE)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rst5_reach", 64'(ok), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst5_state", 64'(ifa.state_id), 64'(IDLE));
    check("rst5_start", 64'(ifa.tx_start), 64'd0);
    check("rst5_data",  64'(ifa.tx_data),  64'd0);
    check("rst5_busy",  64'(ifa.busy),     64'd0);
    check("rst5_done",  64'(ifa.done),     64'd0);
    repeat (15) @(negedge clk);
    check("rst5_no_done", 64'(done_a), 64'd0);
    check("rst5_starts",  64'(st_a.size()), 64'd1);
    run_xfer("after_rst", 0, 64'(16'($urandom)), 0, 0);

    // Randomised words and UART busy windows on both instances.
    for (int i = 0; i < 8; i++) begin
      ulen = $urandom_range(0, 6);
      run_xfer($sformatf("rnd%0d", i), i % 2, {$urandom, $urandom}, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
